// File: rtl/tmr_pkg.sv
// Shared sizes and the replica slice-index helper for the TMR fault monitor.
package tmr_pkg;

  localparam int unsigned NUM_UNITS = 3;
  localparam int unsigned NUM_REPS  = 3;
  localparam int unsigned ERR_CNT_W = 4;

  // LSB of replica rep_idx of unit unit_idx inside the flat replica bus.
  function automatic int unsigned rep_lsb(input int unsigned unit_idx,
                                          input int unsigned rep_idx,
                                          input int unsigned data_w);
    return (unit_idx * NUM_REPS + rep_idx) * data_w;
  endfunction

endpackage

// File: rtl/tmr_maj3.sv
// Combinational bitwise 2-of-3 majority with an all-inputs-equal flag.
module tmr_maj3 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] maj_c_o,
  output logic              all_eq_c_o
);

  assign maj_c_o    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign all_eq_c_o = (a_i == b_i) && (b_i == c_i);

endmodule

// File: rtl/tmr_fault_monitor.sv
// Replica/unit voting, per-unit fault flags and windowed link parity-error rate.
// Optional macro FAULT_FILTER_EN: fault needs two consecutive mismatching samples.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WINDOW = 10
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_UNITS-1:0]                    en,
  input  logic                                    tmr_valid,
  input  logic [NUM_UNITS*NUM_REPS*DATA_W-1:0]    tmr_data,
  input  logic                                    rx_valid,
  input  logic [DATA_W-1:0]                       rx_data,
  input  logic                                    rx_parity,
  output logic [NUM_UNITS-1:0]                    fault,
  output logic [ERR_CNT_W-1:0]                    err_rate,
  output logic                                    out_valid,
  output logic [DATA_W-1:0]                       out_data,
  output logic                                    out_err
);

  logic [DATA_W-1:0]    unit_w [NUM_UNITS];
  logic [NUM_UNITS-1:0] unit_eq;
  logic [NUM_UNITS-1:0] mis;
  logic [DATA_W-1:0]    sys_maj;
  logic                 sys_eq;
  logic                 any_pair_eq;
  logic                 pe;

  logic [NUM_UNITS-1:0] fault_q, fault_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] err_rate_q, err_rate_d;
`ifdef FAULT_FILTER_EN
  logic [NUM_UNITS-1:0] hist_q, hist_d;
`endif

  // Replica vote inside each unit
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    tmr_maj3 #(.DATA_W(DATA_W)) u_maj3 (
      .a_i       (tmr_data[rep_lsb(u, 0, DATA_W) +: DATA_W]),
      .b_i       (tmr_data[rep_lsb(u, 1, DATA_W) +: DATA_W]),
      .c_i       (tmr_data[rep_lsb(u, 2, DATA_W) +: DATA_W]),
      .maj_c_o   (unit_w[u]),
      .all_eq_c_o(unit_eq[u])
    );
  end

  assign mis = ~unit_eq;

  tmr_maj3 #(.DATA_W(DATA_W)) u_sys_maj3 (
    .a_i       (unit_w[0]),
    .b_i       (unit_w[1]),
    .c_i       (unit_w[2]),
    .maj_c_o   (sys_maj),
    .all_eq_c_o(sys_eq)
  );

  // With all three units live, only a three-way disagreement leaves no majority
  assign any_pair_eq = sys_eq || (unit_w[0] == unit_w[1]) ||
                       (unit_w[1] == unit_w[2]) || (unit_w[0] == unit_w[2]);

  assign pe = (^rx_data) ^ rx_parity;

  always_comb begin
    out_valid_d = tmr_valid;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (tmr_valid) begin
      unique case (en)
        3'b111: begin
          out_data_d = sys_maj;
          out_err_d  = !any_pair_eq;
        end
        3'b011: begin
          out_data_d = unit_w[0];
          out_err_d  = (unit_w[0] != unit_w[1]);
        end
        3'b101: begin
          out_data_d = unit_w[0];
          out_err_d  = (unit_w[0] != unit_w[2]);
        end
        3'b110: begin
          out_data_d = unit_w[1];
          out_err_d  = (unit_w[1] != unit_w[2]);
        end
        3'b001: begin
          out_data_d = unit_w[0];
          out_err_d  = mis[0];
        end
        3'b010: begin
          out_data_d = unit_w[1];
          out_err_d  = mis[1];
        end
        3'b100: begin
          out_data_d = unit_w[2];
          out_err_d  = mis[2];
        end
        default: begin
          out_data_d = '0;
          out_err_d  = 1'b1;
        end
      endcase
    end
  end

  // Fault level holds between samples; a disabled unit clears immediately
  always_comb begin
    fault_d = fault_q;
`ifdef FAULT_FILTER_EN
    hist_d  = hist_q;
`endif
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!en[u]) begin
        fault_d[u] = 1'b0;
`ifdef FAULT_FILTER_EN
        hist_d[u]  = 1'b0;
`endif
      end else if (tmr_valid) begin
`ifdef FAULT_FILTER_EN
        fault_d[u] = mis[u] & hist_q[u];
        hist_d[u]  = mis[u];
`else
        fault_d[u] = mis[u];
`endif
      end
    end
  end

  // The closing frame's own error is folded into the published rate
  always_comb begin
    frm_cnt_d  = frm_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_rate_d = err_rate_q;
    if (rx_valid) begin
      if (frm_cnt_q == ERR_CNT_W'(WINDOW - 1)) begin
        err_rate_d = err_cnt_q + ERR_CNT_W'(pe);
        frm_cnt_d  = '0;
        err_cnt_d  = '0;
      end else begin
        frm_cnt_d  = frm_cnt_q + ERR_CNT_W'(1);
        err_cnt_d  = err_cnt_q + ERR_CNT_W'(pe);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_rate_q  <= '0;
`ifdef FAULT_FILTER_EN
      hist_q      <= '0;
`endif
    end else begin
      fault_q     <= fault_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      frm_cnt_q   <= frm_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_rate_q  <= err_rate_d;
`ifdef FAULT_FILTER_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign fault     = fault_q;
  assign err_rate  = err_rate_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: vector table, scoreboard queue, window and reset sequences.
module tb_tmr_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en;
  logic        tmr_valid;
  logic [71:0] tmr_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_parity;
  logic [2:0]  fault;
  logic [3:0]  err_rate;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] fault;
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    logic [2:0]  en;
    logic [71:0] d;
    logic [2:0]  f;
    logic [7:0]  o;
    logic        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[9];

  always #5 clk = ~clk;

  tmr_fault_monitor #(.DATA_W(8), .WINDOW(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .tmr_valid(tmr_valid),
    .tmr_data (tmr_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_parity(rx_parity),
    .fault    (fault),
    .err_rate (err_rate),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_err  (out_err)
  );

  function automatic logic [71:0] mk(input logic [7:0] a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return {c2, c1, c0, b2, b1, b0, a2, a1, a0};
  endfunction

  function automatic logic [71:0] u3(input logic [7:0] a, b, c);
    return mk(a, a, a, b, b, b, c, c, c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_fault(input string name, input logic [2:0] exp);
`ifndef FAULT_FILTER_EN
    chk(name, 32'(fault), 32'(exp));
`endif
  endtask

  task automatic step(input logic [2:0] e, input logic tv, input logic [71:0] d,
                      input logic rv, input logic [7:0] rd, input logic rp);
    @(negedge clk);
    en = e; tmr_valid = tv; tmr_data = d;
    rx_valid = rv; rx_data = rd; rx_parity = rp;
    @(posedge clk);
    #1;
    tmr_valid = 1'b0;
    rx_valid  = 1'b0;
  endtask

  task automatic check_out();
    exp_t x;
    chk("out_valid", 32'(out_valid), 32'd1);
    if (out_valid && sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk("out_data", 32'(out_data), 32'(x.data));
      chk("out_err", 32'(out_err), 32'(x.err));
      chk_fault("fault", x.fault);
    end
  endtask

  task automatic tmr_txn(input logic [2:0] e, input logic [71:0] d,
                         input logic [2:0] f, input logic [7:0] o, input logic er);
    sb_q.push_back('{fault: f, data: o, err: er});
    step(e, 1'b1, d, 1'b0, 8'h00, 1'b0);
    check_out();
  endtask

  task automatic idle(input logic [2:0] e, input int n, input logic [2:0] f,
                      input logic [7:0] o, input logic er);
    for (int i = 0; i < n; i++) begin
      step(e, 1'b0, '0, 1'b0, 8'h00, 1'b0);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("hold_data", 32'(out_data), 32'(o));
      chk("hold_err", 32'(out_err), 32'(er));
      chk_fault("hold_fault", f);
    end
  endtask

  task automatic rx_frame(input logic bad, input logic tv);
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    step(3'b111, tv, u3(8'h44, 8'h44, 8'h44), 1'b1, d, bad ^ (^d));
  endtask

  // Frame 0 of each window also carries a TMR sample on the same edge
  task automatic rx_window(input logic [9:0] bad, input logic [3:0] prev, input logic [3:0] nw);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        sb_q.push_back('{fault: 3'b000, data: 8'h44, err: 1'b0});
        rx_frame(bad[i], 1'b1);
        check_out();
      end else begin
        rx_frame(bad[i], 1'b0);
      end
      if (i < 9) chk("err_rate_mid", 32'(err_rate), 32'(prev));
      else       chk("err_rate_end", 32'(err_rate), 32'(nw));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 3'b000; tmr_valid = 1'b0; tmr_data = '0;
    rx_valid = 1'b0; rx_data = '0; rx_parity = 1'b0;

    vt[0] = '{3'b111, mk(8'h5A,8'h5A,8'h5A, 8'h5A,8'h5A,8'h7A, 8'h5A,8'h5A,8'h5A), 3'b010, 8'h5A, 1'b0};
    vt[1] = '{3'b111, u3(8'h11, 8'h22, 8'h33), 3'b000, 8'h33, 1'b1};
    vt[2] = '{3'b111, mk(8'h11,8'h11,8'h11, 8'h11,8'h11,8'h11, 8'hFF,8'h00,8'h0F), 3'b100, 8'h11, 1'b0};
    vt[3] = '{3'b101, mk(8'h11,8'h11,8'h11, 8'hAA,8'h55,8'h00, 8'h22,8'h22,8'h22), 3'b000, 8'h11, 1'b1};
    vt[4] = '{3'b110, u3(8'h00, 8'h3C, 8'h3C), 3'b000, 8'h3C, 1'b0};
    vt[5] = '{3'b010, mk(8'h00,8'h00,8'h00, 8'h80,8'h80,8'h81, 8'h00,8'h00,8'h00), 3'b010, 8'h80, 1'b1};
    vt[6] = '{3'b100, u3(8'h00, 8'h00, 8'hC3), 3'b000, 8'hC3, 1'b0};
    vt[7] = '{3'b000, mk(8'h01,8'h02,8'h03, 8'h01,8'h02,8'h03, 8'h01,8'h02,8'h03), 3'b000, 8'h00, 1'b1};
    vt[8] = '{3'b011, mk(8'h0F,8'h0F,8'h00, 8'hF0,8'hF0,8'hF0, 8'h00,8'h00,8'h00), 3'b001, 8'h0F, 1'b1};

    #12;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_err_rate", 32'(err_rate), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) tmr_txn(vt[i].en, vt[i].d, vt[i].f, vt[i].o, vt[i].e);

    // Single upset, fault holds across idle cycles, then disabling unit1 clears it
    tmr_txn(3'b111, vt[0].d, 3'b010, 8'h5A, 1'b0);
    idle(3'b111, 3, 3'b010, 8'h5A, 1'b0);
    idle(3'b101, 1, 3'b000, 8'h5A, 1'b0);
    tmr_txn(3'b101, mk(8'h11,8'h11,8'h11, 8'hAA,8'h55,8'h00, 8'h22,8'h22,8'h22), 3'b000, 8'h11, 1'b1);

    rx_window(10'b1011010101, 4'd0, 4'd6);
    rx_window(10'b0000000000, 4'd6, 4'd0);
    rx_window(10'b0000111100, 4'd0, 4'd4);

    // Partial window of errors, then async reset while a sample is in flight
    for (int i = 0; i < 5; i++) rx_frame(i < 3, 1'b0);
    @(negedge clk);
    en = 3'b111; tmr_valid = 1'b1; tmr_data = vt[0].d;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tmr_valid = 1'b0;
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_err_rate", 32'(err_rate), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_window(10'b0000000100, 4'd0, 4'd1);

`ifdef FAULT_FILTER_EN
    // Isolated mismatches on unit0 never raise fault; two in a row do
    step(3'b111, 1'b1, u3(8'h5A, 8'h5A, 8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_clean", 32'(fault), 32'd0);
    step(3'b111, 1'b1, mk(8'h5A,8'h5A,8'h5B, 8'h5A,8'h5A,8'h5A, 8'h5A,8'h5A,8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_mis1", 32'(fault), 32'd0);
    step(3'b111, 1'b1, u3(8'h5A, 8'h5A, 8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_clean2", 32'(fault), 32'd0);
    step(3'b111, 1'b1, mk(8'h5A,8'h5A,8'h5B, 8'h5A,8'h5A,8'h5A, 8'h5A,8'h5A,8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_mis_a", 32'(fault), 32'd0);
    step(3'b111, 1'b1, mk(8'h5A,8'h5A,8'h5B, 8'h5A,8'h5A,8'h5A, 8'h5A,8'h5A,8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_mis_b", 32'(fault), 32'd1);
    step(3'b111, 1'b1, u3(8'h5A, 8'h5A, 8'h5A), 1'b0, 8'h00, 1'b0);
    chk("filt_clear", 32'(fault), 32'd0);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
